// File: rtl/param_allocator.sv
// param_allocator: computes one output pixel of a convolution.
//
// A centre position and the filter configuration are latched on
// center_write_enable. Broadcast image samples that fall inside the window,
// and the in-order filter weights, are captured into two circular buffers.
// A pipelined signed MACC drains both buffers in lock-step. The finished sum
// gets the bias added, an optional leaky ReLU, and saturation to DATA_W, and
// is then offered on a valid/ready handshake.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   image_valid/x/y/data          broadcast sample stream, image_block = hold
//   filter_valid/data             in-order weight stream, filter_block = hold
//   center_x/y, center_write_enable,
//   filter_halfsize/bias/length   pixel start and configuration (IDLE only)
//   busy                          pixel in progress (RUN or RESULT)
//   result_valid/data/ready       activated, saturated result handshake

// Circular buffer with registered read data. A push is refused when the
// buffer is full, even if a pop happens in the same cycle.
module param_allocator_cbuf #(
  parameter int DATA_W    = 18,
  parameter int BUF_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == (PTR_W+1)'(BUF_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  // Pointers are PTR_W wide, so incrementing wraps modulo BUF_DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdata  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module param_allocator #(
  parameter int DATA_W     = 18,
  parameter int COORD_W    = 8,
  parameter int CNT_W      = 13,
  parameter int BUF_DEPTH  = 1024,
  parameter int ACC_W      = 48,
  parameter int RELU_EN    = 1,
  parameter int LEAK_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               image_valid,
  input  logic [COORD_W-1:0] image_x,
  input  logic [COORD_W-1:0] image_y,
  input  logic [DATA_W-1:0]  image_data,
  output logic               image_block,
  input  logic               filter_valid,
  input  logic [DATA_W-1:0]  filter_data,
  output logic               filter_block,
  input  logic [COORD_W-1:0] center_x,
  input  logic [COORD_W-1:0] center_y,
  input  logic               center_write_enable,
  input  logic [1:0]         filter_halfsize,
  input  logic [DATA_W-1:0]  filter_bias,
  input  logic [CNT_W-1:0]   filter_length,
  output logic               busy,
  output logic               result_valid,
  output logic [DATA_W-1:0]  result_data,
  input  logic               result_ready
);
  localparam int PROD_W     = 2 * DATA_W;
  localparam int MAC_STAGES = 2;
  localparam int IMG        = 0;
  localparam int FLT        = 1;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;
  state_t state, state_nx;

  // Latched pixel configuration
  logic [COORD_W-1:0]       cfg_cx, cfg_cy;
  logic [1:0]               cfg_hs;
  logic signed [DATA_W-1:0] cfg_bias;
  logic [CNT_W-1:0]         cfg_len;

  // Progress counters
  logic [CNT_W-1:0] img_acc, flt_acc, issued, macs_done;

  // MAC datapath
  logic [MAC_STAGES:1]      vld_pipe;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  logic start, in_win, img_push, flt_push, mac_pop;

  logic [1:0]             buf_push, buf_full, buf_empty;
  logic [1:0][DATA_W-1:0] buf_wdata, buf_rdata;

  // Window test in COORD_W+1 signed arithmetic: no wrap at the image edges,
  // so a centre at 0 never accepts coordinates near the top of the range.
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0]        adx, ady, hs_ext;

  assign dx     = $signed({1'b0, image_x}) - $signed({1'b0, cfg_cx});
  assign dy     = $signed({1'b0, image_y}) - $signed({1'b0, cfg_cy});
  assign adx    = dx[COORD_W] ? -dx : dx;
  assign ady    = dy[COORD_W] ? -dy : dy;
  assign hs_ext = {{(COORD_W-1){1'b0}}, cfg_hs};
  assign in_win = (adx <= hs_ext) && (ady <= hs_ext);

  assign start = (state == IDLE) && center_write_enable;

  // Out-of-window and surplus transfers still handshake; they are just
  // not pushed.
  assign img_push = (state == RUN) && image_valid && !buf_full[IMG] &&
                    in_win && (img_acc < cfg_len);
  assign flt_push = (state == RUN) && filter_valid && !buf_full[FLT] &&
                    (flt_acc < cfg_len);
  assign mac_pop  = (state == RUN) && !buf_empty[IMG] && !buf_empty[FLT] &&
                    (issued < cfg_len);

  assign buf_push  = {flt_push, img_push};
  assign buf_wdata = {filter_data, image_data};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_buf
      param_allocator_cbuf #(
        .DATA_W   (DATA_W),
        .BUF_DEPTH(BUF_DEPTH)
      ) u_cbuf (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .push (buf_push[g]),
        .pop  (mac_pop),
        .wdata(buf_wdata[g]),
        .rdata(buf_rdata[g]),
        .full (buf_full[g]),
        .empty(buf_empty[g])
      );
    end
  endgenerate

  assign image_block  = (state == RUN) && buf_full[IMG];
  assign filter_block = (state == RUN) && buf_full[FLT];
  assign busy         = (state != IDLE);

  // Bias, activation and saturation of the final accumulator.
  logic signed [ACC_W-1:0]  sum, act;
  logic signed [DATA_W-1:0] sat;

  assign sum = acc + ACC_W'(cfg_bias);
  assign act = ((RELU_EN != 0) && (sum < 0)) ? (sum >>> LEAK_SHIFT) : sum;

  always_comb begin
    sat = act[DATA_W-1:0];
    if (act > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (act < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (center_write_enable) state_nx = RUN;
      // Zero length leaves RUN on its first cycle with acc = 0.
      RUN:     if (macs_done == cfg_len) state_nx = RESULT;
      RESULT:  if (result_valid && result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cfg_cx       <= '0;
      cfg_cy       <= '0;
      cfg_hs       <= '0;
      cfg_bias     <= '0;
      cfg_len      <= '0;
      img_acc      <= '0;
      flt_acc      <= '0;
      issued       <= '0;
      macs_done    <= '0;
      vld_pipe     <= '0;
      prod         <= '0;
      acc          <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        cfg_cx    <= center_x;
        cfg_cy    <= center_y;
        cfg_hs    <= filter_halfsize;
        cfg_bias  <= filter_bias;
        cfg_len   <= filter_length;
        img_acc   <= '0;
        flt_acc   <= '0;
        issued    <= '0;
        macs_done <= '0;
        vld_pipe  <= '0;
        acc       <= '0;
      end else begin
        if (img_push) img_acc <= img_acc + 1'b1;
        if (flt_push) flt_acc <= flt_acc + 1'b1;
        if (mac_pop)  issued  <= issued + 1'b1;
        // pop -> operands registered (stage 1) -> product (stage 2) -> acc
        vld_pipe <= {vld_pipe[1], mac_pop};
        if (vld_pipe[1])
          prod <= $signed(buf_rdata[IMG]) * $signed(buf_rdata[FLT]);
        if (vld_pipe[2]) begin
          acc       <= acc + ACC_W'(prod);
          macs_done <= macs_done + 1'b1;
        end
      end

      // result_data keeps its value after the handshake.
      if ((state == RESULT) && !result_valid) begin
        result_valid <= 1'b1;
        result_data  <= sat;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_param_allocator.sv
module tb_param_allocator;
  localparam int DW = 18;
  localparam int CW = 8;
  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          image_valid = 1'b0;
  logic [CW-1:0] image_x = '0, image_y = '0;
  logic [DW-1:0] image_data = '0;
  logic          image_block;
  logic          filter_valid = 1'b0;
  logic [DW-1:0] filter_data = '0;
  logic          filter_block;
  logic [CW-1:0] center_x = '0, center_y = '0;
  logic          center_write_enable = 1'b0;
  logic [1:0]    filter_halfsize = '0;
  logic [DW-1:0] filter_bias = '0;
  logic [NW-1:0] filter_length = '0;
  logic          busy;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic          result_ready = 1'b1;

  param_allocator #(
    .DATA_W(DW), .COORD_W(CW), .CNT_W(NW), .BUF_DEPTH(4),
    .ACC_W(48), .RELU_EN(1), .LEAK_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .image_valid(image_valid), .image_x(image_x), .image_y(image_y),
    .image_data(image_data), .image_block(image_block),
    .filter_valid(filter_valid), .filter_data(filter_data),
    .filter_block(filter_block),
    .center_x(center_x), .center_y(center_y),
    .center_write_enable(center_write_enable),
    .filter_halfsize(filter_halfsize), .filter_bias(filter_bias),
    .filter_length(filter_length), .busy(busy),
    .result_valid(result_valid), .result_data(result_data),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [DW-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Scoreboard monitor: every accepted result is checked against the queue.
  always @(negedge clk) begin
    if (rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d expected none",
                 $signed(result_data));
      end else begin
        chk("result", longint'($signed(result_data)), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_img(input int x, input int y, input int d);
    int  n;
    bit  ok;
    image_x = CW'(x); image_y = CW'(y); image_data = DW'(d);
    image_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = !image_block; @(posedge clk); n++;
    end while (!ok && n < 300);
    #1 image_valid = 1'b0;
    if (!ok) timeout("img_send");
  endtask

  task automatic send_flt(input int d);
    int  n;
    bit  ok;
    filter_data = DW'(d);
    filter_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = !filter_block; @(posedge clk); n++;
    end while (!ok && n < 300);
    #1 filter_valid = 1'b0;
    if (!ok) timeout("flt_send");
  endtask

  task automatic start(input int cx, input int cy, input int hs,
                       input int bias, input int len);
    @(posedge clk); #1;
    center_x = CW'(cx); center_y = CW'(cy); filter_halfsize = 2'(hs);
    filter_bias = DW'(bias); filter_length = NW'(len);
    center_write_enable = 1'b1;
    @(posedge clk); #1 center_write_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
    if (busy) timeout(name);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_image_block", image_block, 0);
    chk("rst_filter_block", filter_block, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_data", result_data, 0);
    rst = 1'b1;

    // 3x3 window around (10,10) out of a 5x5 broadcast: 9 * 1 * 2 = 18
    start(10, 10, 1, 0, 9);
    exp_q.push_back(18);
    chk("busy_run", busy, 1);
    fork
      begin
        for (int y = 8; y <= 12; y++)
          for (int x = 8; x <= 12; x++) send_img(x, y, 1);
      end
      begin
        for (int i = 0; i < 9; i++) send_flt(2);
      end
    join
    wait_idle("window");
    chk("window_data_held", $signed(result_data), 18);
    chk("window_valid_dropped", result_valid, 0);

    // Centre (0,0): x=255 / y=255 must not wrap into the window -> 1+2+3+4
    start(0, 0, 1, 0, 4);
    exp_q.push_back(10);
    fork
      begin
        send_img(0, 0, 1);   send_img(1, 0, 2);
        send_img(255, 0, 100); send_img(0, 255, 100);
        send_img(0, 1, 3);   send_img(1, 1, 4);
      end
      begin
        for (int i = 0; i < 4; i++) send_flt(1);
      end
    join
    wait_idle("edge");

    // Backpressure with a depth-4 buffer: images 1..8, weights 1 -> 36
    start(5, 5, 0, 0, 8);
    exp_q.push_back(36);
    for (int i = 1; i <= 4; i++) send_img(5, 5, i);
    @(negedge clk);
    chk("img_block_full", image_block, 1);
    chk("flt_block_idle", filter_block, 0);
    send_flt(1);
    n = 0;
    while (image_block && n < 10) begin @(negedge clk); n++; end
    chk("img_block_release", image_block, 0);
    fork
      begin
        for (int i = 5; i <= 8; i++) send_img(5, 5, i);
      end
      begin
        for (int i = 0; i < 7; i++) send_flt(1);
      end
    join
    wait_idle("backpressure");

    // Leaky ReLU: -16*4 = -64, >>>3 = -8; last pop one cycle after weight
    start(0, 0, 0, 0, 1);
    exp_q.push_back(-8);
    send_img(0, 0, -16);
    send_flt(4);
    repeat (4) @(posedge clk);
    #1 chk("latency_not_yet", result_valid, 0);
    @(posedge clk);
    #1 chk("latency_pop_plus5", result_valid, 1);
    wait_idle("leaky");

    // Positive saturation
    start(0, 0, 0, 0, 4);
    exp_q.push_back(131071);
    fork
      begin for (int i = 0; i < 4; i++) send_img(0, 0, 131071); end
      begin for (int i = 0; i < 4; i++) send_flt(131071); end
    join
    wait_idle("sat_pos");

    // Negative saturation (leak shift still far below the minimum)
    start(0, 0, 0, 0, 2);
    exp_q.push_back(-131072);
    fork
      begin for (int i = 0; i < 2; i++) send_img(0, 0, 131071); end
      begin for (int i = 0; i < 2; i++) send_flt(-131072); end
    join
    wait_idle("sat_neg");

    // Zero length: result is the activated bias (-5 >>> 3 = -1)
    start(0, 0, 0, -5, 0);
    exp_q.push_back(-1);
    wait_idle("zero_len_neg");
    start(0, 0, 0, 5, 0);
    exp_q.push_back(5);
    wait_idle("zero_len_pos");

    // Handshake hold; a centre write while the result waits is ignored
    result_ready = 1'b0;
    start(0, 0, 0, 7, 0);
    exp_q.push_back(7);
    repeat (4) @(posedge clk);
    #1;
    filter_bias = DW'(99); filter_length = NW'(4);
    center_write_enable = 1'b1;
    @(posedge clk); #1 center_write_enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_valid", result_valid, 1);
    chk("hold_data", $signed(result_data), 7);
    chk("hold_busy", busy, 1);
    result_ready = 1'b1;
    wait_idle("handshake");
    repeat (3) @(negedge clk);
    chk("ignored_cwe_idle", busy, 0);

    // Asynchronous reset in the middle of RUN, then a clean pixel
    start(0, 0, 0, 0, 4);
    send_img(0, 0, 1);
    send_img(0, 0, 1);
    send_flt(1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", result_valid, 0);
    chk("async_rst_data", result_data, 0);
    chk("async_rst_img_block", image_block, 0);
    @(posedge clk); #1 rst = 1'b1;
    start(0, 0, 0, 3, 2);
    exp_q.push_back(8);
    send_img(0, 0, 2);
    send_img(0, 0, 3);
    send_flt(1);
    send_flt(1);
    wait_idle("after_reset");

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
